// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
package piso_pkg;

    // Controller states: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default parallel word width.
    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/piso_bit_cnt.sv
// Down-counter tracking how many bits of the current word remain after the
// one being presented; is_last flags the final bit of the word.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       en,
    output logic [$clog2(WIDTH):0]     cnt,
    output logic                       is_last
);

    localparam int                CW    = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]     LOADV = CW'(WIDTH - 1);
    localparam logic [CW-1:0]     ONE   = CW'(1);

    // Load on a new word, otherwise count down once per consumed bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOADV;
        end else if (en) begin
            cnt <= cnt - ONE;
        end
    end

    assign is_last = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready handshakes on both
// sides. A new word may be accepted in the same cycle the last bit of the
// previous word is consumed, giving gap-free back-to-back streaming.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int            CW  = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    cnt;
    logic             is_last;
    logic             accept;
    logic             advance;
    logic             ser_out_r;
    logic             frame_start_r;
    logic             done_r;

    // Bit that goes on the wire first for a given register image.
    function automatic logic lead_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    // Register image after the presented bit has been consumed.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    // Ready is combinational so a word can slip in on the last-bit edge;
    // it is forced low during reset so no accept competes with it.
    assign in_ready = !rst && ((state == IDLE) || (done_r && ser_ready));
    assign accept   = in_valid && in_ready;
    assign advance  = (state == SHIFT) && ser_ready;

    assign shreg_nxt = shift_word(shreg);

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .en      (advance && !is_last),
        .cnt     (cnt),
        .is_last (is_last)
    );

    // Controller and output registers: load on accept, shift on consumption,
    // drop to IDLE after the last bit unless a new word arrives with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            ser_out_r     <= 1'b0;
            frame_start_r <= 1'b0;
            done_r        <= 1'b0;
        end else if (accept) begin
            state         <= SHIFT;
            shreg         <= in_data;
            ser_out_r     <= lead_bit(in_data);
            frame_start_r <= 1'b1;
            done_r        <= (WIDTH == 1);
        end else if (advance) begin
            if (done_r) begin
                state         <= IDLE;
                shreg         <= '0;
                ser_out_r     <= 1'b0;
                frame_start_r <= 1'b0;
                done_r        <= 1'b0;
            end else begin
                shreg         <= shreg_nxt;
                ser_out_r     <= lead_bit(shreg_nxt);
                frame_start_r <= 1'b0;
                done_r        <= (cnt == ONE);
            end
        end
    end

    assign ser_out     = ser_out_r;
    assign frame_start = frame_start_r;
    assign done        = done_r;
    assign ser_valid   = (state == SHIFT);
    assign busy        = (state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an 8-bit MSB-first instance watched by a bit
// scoreboard, plus an 8-bit LSB-first and a 1-bit instance.
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic fs;
        logic dn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main instance: WIDTH=8, MSB first
    logic       m_in_valid = 1'b0, m_ser_ready = 1'b1;
    logic [7:0] m_in_data = '0;
    logic       m_in_ready, m_ser_out, m_ser_valid, m_fs, m_done, m_busy;
    // LSB-first instance
    logic       l_in_valid = 1'b0;
    logic [7:0] l_in_data = '0;
    logic       l_in_ready, l_ser_out, l_ser_valid, l_fs, l_done, l_busy;
    // 1-bit instance
    logic       w_in_valid = 1'b0;
    logic [0:0] w_in_data = '0;
    logic       w_in_ready, w_ser_out, w_ser_valid, w_fs, w_done, w_busy;

    int   errs = 0;
    int   chks = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_data(m_in_data), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
        .ser_ready(m_ser_ready), .frame_start(m_fs), .done(m_done), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .in_data(l_in_data), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
        .ser_ready(1'b1), .frame_start(l_fs), .done(l_done), .busy(l_busy)
    );

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .ser_out(w_ser_out), .ser_valid(w_ser_valid),
        .ser_ready(1'b1), .frame_start(w_fs), .done(w_done), .busy(w_busy)
    );

    // Expected bits of one MSB-first word, with frame markers.
    task automatic push_word(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.b  = d[7-i];
            e.fs = (i == 0);
            e.dn = (i == 7);
            sbq.push_back(e);
        end
    endtask

    // Scoreboard: every consumed bit of the main instance is popped and compared.
    always @(negedge clk) begin
        if (!rst && m_ser_valid && m_ser_ready) begin
            chks++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL sb_extra_bit: got bit %0b, expected no bit", m_ser_out);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if ({m_ser_out, m_fs, m_done} !== {e.b, e.fs, e.dn}) begin
                    errs++;
                    $display("FAIL sb_bit: got {out,fs,done}=%b, expected %b",
                             {m_ser_out, m_fs, m_done}, {e.b, e.fs, e.dn});
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        m_in_valid = 1'b1;
        m_in_data = 8'hFF;
        @(negedge clk);
        chks++;
        if ({m_ser_out, m_ser_valid, m_fs, m_done, m_busy} !== 5'b0) begin
            errs++;
            $display("FAIL reset_outputs: got %b, expected 00000",
                     {m_ser_out, m_ser_valid, m_fs, m_done, m_busy});
        end
        chks++;
        if (m_in_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_in_ready: got %b, expected 0", m_in_ready);
        end
        @(negedge clk);
        chks++;
        if (m_ser_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_overrides_accept: got ser_valid=%b, expected 0", m_ser_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_in_valid = 1'b0;
        @(negedge clk);
        chks++;
        if ({m_in_ready, m_busy} !== 2'b10) begin
            errs++;
            $display("FAIL idle_ready: got {in_ready,busy}=%b, expected 10", {m_in_ready, m_busy});
        end
    endtask

    // Single word with ser_ready held high; also covers the return to IDLE.
    task automatic test_single(input string nm, input logic [7:0] d);
        @(posedge clk); #1;
        m_in_data = d;
        m_in_valid = 1'b1;
        push_word(d);
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chks++;
            if ({m_ser_valid, m_fs, m_done, m_in_ready} !== {1'b1, c == 1, c == 8, c == 8}) begin
                errs++;
                $display("FAIL %s_cycle%0d: got {valid,fs,done,in_ready}=%b, expected %b", nm, c,
                         {m_ser_valid, m_fs, m_done, m_in_ready}, {1'b1, c == 1, c == 8, c == 8});
            end
        end
        @(negedge clk);
        chks++;
        if ({m_ser_valid, m_ser_out, m_busy, m_in_ready} !== 4'b0001) begin
            errs++;
            $display("FAIL %s_idle: got {valid,out,busy,in_ready}=%b, expected 0001", nm,
                     {m_ser_valid, m_ser_out, m_busy, m_in_ready});
        end
        chks++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL %s_bits_left: got %0d unsent bits, expected 0", nm, sbq.size());
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] words [2];
        words[0] = 8'h01;
        words[1] = 8'hB4;
        for (int w = 0; w < 2; w++) begin
            @(posedge clk); #1;
            l_in_data = words[w];
            l_in_valid = 1'b1;
            @(posedge clk); #1;
            l_in_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chks++;
                if ({l_ser_valid, l_ser_out} !== {1'b1, words[w][i]}) begin
                    errs++;
                    $display("FAIL lsb_w%0d_bit%0d: got {valid,out}=%b, expected %b", w, i,
                             {l_ser_valid, l_ser_out}, {1'b1, words[w][i]});
                end
            end
            @(negedge clk);
            chks++;
            if ({l_ser_valid, l_ser_out} !== 2'b00) begin
                errs++;
                $display("FAIL lsb_w%0d_idle: got {valid,out}=%b, expected 00", w, {l_ser_valid, l_ser_out});
            end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        m_in_data = 8'hFF;
        m_in_valid = 1'b1;
        push_word(8'hFF);
        push_word(8'h00);
        @(posedge clk); #1;
        m_in_data = 8'h00;  // changes mid-word; must not disturb the FF bits
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chks++;
            if (m_ser_valid !== 1'b1) begin
                errs++;
                $display("FAIL b2b_valid%0d: got %b, expected 1", c, m_ser_valid);
            end
            if (c < 16) begin
                chks++;
                if (m_in_ready !== (c == 8)) begin
                    errs++;
                    $display("FAIL b2b_ready%0d: got %b, expected %b", c, m_in_ready, c == 8);
                end
            end
            if (c == 8) begin
                @(posedge clk); #1;
                m_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chks++;
        if ({m_ser_valid, sbq.size() == 0} !== 2'b01) begin
            errs++;
            $display("FAIL b2b_end: got valid=%b left=%0d, expected valid=0 left=0", m_ser_valid, sbq.size());
        end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        m_in_data = 8'hC3;
        m_in_valid = 1'b1;
        push_word(8'hC3);
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            m_ser_ready = !(c >= 4 && c <= 6);
            @(negedge clk);
            chks++;
            if (m_ser_valid !== (c <= 11)) begin
                errs++;
                $display("FAIL stall_valid%0d: got %b, expected %b", c, m_ser_valid, c <= 11);
            end
            if (c >= 4 && c <= 7) begin
                chks++;
                if ({m_ser_out, m_fs, m_done} !== 3'b000) begin
                    errs++;
                    $display("FAIL stall_hold%0d: got {out,fs,done}=%b, expected 000", c,
                             {m_ser_out, m_fs, m_done});
                end
            end
            if (c == 11) begin
                chks++;
                if ({m_ser_out, m_done} !== 2'b11) begin
                    errs++;
                    $display("FAIL stall_last: got {out,done}=%b, expected 11", {m_ser_out, m_done});
                end
            end
            @(posedge clk); #1;
        end
        m_ser_ready = 1'b1;
        chks++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL stall_bits_left: got %0d, expected 0", sbq.size());
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        m_in_data = 8'h3C;
        m_in_valid = 1'b1;
        push_word(8'h3C);
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;  // asserted while bit 5 is presented
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chks++;
        if ({m_ser_out, m_ser_valid, m_fs, m_done, m_busy} !== 5'b0) begin
            errs++;
            $display("FAIL rstmid_outputs: got %b, expected 00000",
                     {m_ser_out, m_ser_valid, m_fs, m_done, m_busy});
        end
        chks++;
        if (sbq.size() != 4) begin
            errs++;
            $display("FAIL rstmid_sent: got %0d unsent bits, expected 4", sbq.size());
        end
        sbq.delete();
        chks++;
        if (m_in_ready !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_ready: got %b, expected 1", m_in_ready);
        end
        test_single("after_rst_81", 8'h81);
    endtask

    task automatic test_width1();
        for (int v = 1; v >= 0; v--) begin
            @(posedge clk); #1;
            w_in_data = 1'(v);
            w_in_valid = 1'b1;
            @(posedge clk); #1;
            w_in_valid = 1'b0;
            @(negedge clk);
            chks++;
            if ({w_ser_valid, w_ser_out, w_fs, w_done} !== {1'b1, 1'(v), 1'b1, 1'b1}) begin
                errs++;
                $display("FAIL w1_bit_v%0d: got {valid,out,fs,done}=%b, expected %b", v,
                         {w_ser_valid, w_ser_out, w_fs, w_done}, {1'b1, 1'(v), 1'b1, 1'b1});
            end
            @(negedge clk);
            chks++;
            if ({w_ser_valid, w_ser_out, w_fs, w_done} !== 4'b0000) begin
                errs++;
                $display("FAIL w1_idle_v%0d: got %b, expected 0000", v,
                         {w_ser_valid, w_ser_out, w_fs, w_done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single("a5", 8'hA5);
        test_lsb_first();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_width1();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
